mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS main control FSM. Drives every datapath mux select (2:1 and 4:1)
//  plus register-file, memory, IR and PC write enables. Sits directly upstream of the
//  datapath muxes; opcode comes from the instruction register. Memory stalls via mem_ready.
// PARAMETERS
//  OP_RTYPE  6'h00  R-type opcode
//  OP_LW     6'h23  load word
//  OP_SW     6'h2B  store word
//  OP_BEQ    6'h04  branch equal
//  OP_ADDI   6'h08  add immediate
//  OP_J      6'h02  jump
// PORTS
//  clk            in   1  clock, rising edge
//  rst_n          in   1  async active-low reset
//  opcode         in   6  IR[31:26], sampled in DECODE
//  mem_ready      in   1  memory completes access this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero
//  i_or_d         out  1  mem addr mux: 0=PC 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  IR load
//  mem_to_reg     out  1  WB mux: 0=ALUOut 1=MDR
//  reg_dst        out  1  dest mux: 0=rt 1=rd
//  reg_write      out  1  register-file write
//  alu_src_a      out  1  0=PC 1=A
//  alu_src_b      out  2  0=B 1=const 4 2=sign-ext imm 3=sign-ext imm<<2
//  alu_op         out  2  0=add 1=sub 2=funct-decoded
//  pc_source      out  2  0=ALU result 1=ALUOut 2=jump target
//  illegal_op     out  1  one-cycle pulse: unknown opcode in DECODE
//  state_o        out  4  current state (debug)
// BEHAVIOUR
//  - State register (4b) only sequential element; outputs decoded from state (Moore),
//    except pc_write/ir_write in FETCH, which are ANDed with mem_ready.
//  - Encoding: RST=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 REX=7 RWB=8
//    BEQ=9 AIEX=10 AIWB=11 JEX=12; codes 13-15 -> FETCH next cycle, outputs all 0.
//  - rst_n low: state=RST immediately (async), any cycle incl. mid-instruction.
//    RST: every output 0. First edge after release -> FETCH.
//  - Unlisted outputs are 0 in each state:
//    FETCH : mem_read, alu_src_b=1, ir_write&pc_write=mem_ready; stay until mem_ready, then DECODE
//    DECODE: alu_src_b=3; next by opcode: LW/SW->MEMADR, RTYPE->REX, BEQ->BEQ,
//            ADDI->AIEX, J->JEX, other->FETCH with illegal_op=1 (combinational, this cycle)
//    MEMADR: alu_src_a=1 alu_src_b=2; LW->MEMRD, SW->MEMWR (opcode held stable by IR)
//    MEMRD : mem_read i_or_d=1; stay until mem_ready -> MEMWB
//    MEMWB : reg_write mem_to_reg=1 reg_dst=0 -> FETCH
//    MEMWR : mem_write i_or_d=1; stay until mem_ready -> FETCH
//    REX   : alu_src_a=1 alu_src_b=0 alu_op=2 -> RWB
//    RWB   : reg_write reg_dst=1 mem_to_reg=0 -> FETCH
//    BEQ   : alu_src_a=1 alu_src_b=0 alu_op=1 pc_write_cond pc_source=1 -> FETCH
//    AIEX  : alu_src_a=1 alu_src_b=2 alu_op=0 -> AIWB
//    AIWB  : reg_write reg_dst=0 mem_to_reg=0 -> FETCH
//    JEX   : pc_write pc_source=2 -> FETCH
//  - Latency (mem_ready=1): R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3 cycles; each stall cycle +1.
//  - mem_write and mem_read never both 1; reg_write never with mem_read/mem_write.
// TESTING
//  1 rst_n=0 mid-MEMRD -> state_o=0 and all outputs 0 same cycle; release -> FETCH next edge.
//  2 opcode=6'h00, mem_ready=1 -> states 1,2,7,8,1; RWB: reg_write=1 reg_dst=1.
//  3 opcode=6'h23, mem_ready low 3 cycles in MEMRD -> stays 4 with mem_read=1, then 5, reg_write+mem_to_reg.
//  4 opcode=6'h04 -> BEQ cycle: pc_write_cond=1 alu_op=01 pc_source=01; FETCH next.
//  5 opcode=6'h3F -> illegal_op=1 for exactly the DECODE cycle; next state FETCH; no writes.
//  6 FETCH with mem_ready=0 -> ir_write=0 pc_write=0 mem_read=1; mem_ready=1 -> both pulse once.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM.
// Drives the datapath mux selects and the write enables from a 4-bit state register.
// The outputs are Moore-decoded from that register, with three exceptions:
// FETCH gates ir_write/pc_write with mem_ready, and DECODE flags an unknown opcode
// combinationally in the same cycle.
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        StRst    = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StRex    = 4'd7,
        StRwb    = 4'd8,
        StBeq    = 4'd9,
        StAiex   = 4'd10,
        StAiwb   = 4'd11,
        StJex    = 4'd12
    } state_e;

    state_e state_q, state_d;

    // Next-state selection; unused codes 13-15 fall back to FETCH.
    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StRst:    state_d = StFetch;
            StFetch:  state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = StMemAdr;
                else if (opcode == OP_RTYPE)            state_d = StRex;
                else if (opcode == OP_BEQ)              state_d = StBeq;
                else if (opcode == OP_ADDI)             state_d = StAiex;
                else if (opcode == OP_J)                state_d = StJex;
                else                                    state_d = StFetch;
            end
            // IR holds the opcode, so it is still valid here.
            StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
            StRex:    state_d = StRwb;
            StRwb:    state_d = StFetch;
            StBeq:    state_d = StFetch;
            StAiex:   state_d = StAiwb;
            StAiwb:   state_d = StFetch;
            StJex:    state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // State register; the asynchronous reset can abort any instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StRst;
        else        state_q <= state_d;
    end

    // Output decode from the current state; every output defaults to 0.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        illegal_op    = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                // Commit PC+4 and the IR only once the instruction word arrives.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b  = 2'd3;
                illegal_op = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE ||
                               opcode == OP_BEQ || opcode == OP_ADDI || opcode == OP_J);
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            StRex: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            StRwb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBeq: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            StAiex: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            StAiwb: begin
                reg_write = 1'b1;
            end
            StJex: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            default: ;
        endcase
    end

    // Debug view of the current state.
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    int checks;
    int errors;

    mc_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state_o       (state_o)
    );

    // Packed output view, field order:
    // pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg reg_dst
    // reg_write alu_src_a alu_src_b[2] alu_op[2] pc_source[2] illegal_op
    logic [16:0] outs;
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

    localparam logic [16:0] EXP_ZERO     = 17'd0;
    localparam logic [16:0] EXP_FETCH_RDY =
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_FETCH_WAIT =
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_DECODE =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_DECODE_ILL =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1};
    localparam logic [16:0] EXP_MEMADR =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_MEMRD =
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_MEMWB =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_MEMWR =
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_REX =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0};
    localparam logic [16:0] EXP_RWB =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_BEQ =
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd1, 1'b0};
    localparam logic [16:0] EXP_AIEX =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_AIWB =
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] EXP_JEX =
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (state_o !== 4'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", state_o);
        end
        checks++;
        if (outs !== EXP_ZERO) begin
            errors++; $display("FAIL reset_outs: got %h want %h", outs, EXP_ZERO);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state_o !== 4'd1) begin
            errors++; $display("FAIL reset_release: got %0d want 1", state_o);
        end
        checks++;
        if (outs !== EXP_FETCH_RDY) begin
            errors++; $display("FAIL reset_fetch_outs: got %h want %h", outs, EXP_FETCH_RDY);
        end
    endtask

    // R-type: 1,2,7,8,1 with mem_ready held high.
    task automatic test_rtype();
        logic [3:0]  st [5] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        logic [16:0] ex [5] = '{EXP_FETCH_RDY, EXP_DECODE, EXP_REX, EXP_RWB, EXP_FETCH_RDY};
        opcode    = 6'h00;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state_o !== st[i] || outs !== ex[i]) begin
                errors++;
                $display("FAIL rtype_step%0d: got state %0d outs %h want state %0d outs %h",
                         i, state_o, outs, st[i], ex[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    // LW with three stall cycles in MEMRD.
    task automatic test_lw_stall();
        opcode    = 6'h23;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state_o !== 4'd3 || outs !== EXP_MEMADR) begin
            errors++; $display("FAIL lw_memadr: got state %0d outs %h want 3 %h",
                               state_o, outs, EXP_MEMADR);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            checks++;
            if (state_o !== 4'd4 || outs !== EXP_MEMRD) begin
                errors++; $display("FAIL lw_stall%0d: got state %0d outs %h want 4 %h",
                                   i, state_o, outs, EXP_MEMRD);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        checks++;
        if (state_o !== 4'd4 || outs !== EXP_MEMRD) begin
            errors++; $display("FAIL lw_memrd_last: got state %0d outs %h want 4 %h",
                               state_o, outs, EXP_MEMRD);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd5 || outs !== EXP_MEMWB) begin
            errors++; $display("FAIL lw_memwb: got state %0d outs %h want 5 %h",
                               state_o, outs, EXP_MEMWB);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd1) begin
            errors++; $display("FAIL lw_back_to_fetch: got %0d want 1", state_o);
        end
    endtask

    task automatic test_beq();
        opcode    = 6'h04;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state_o !== 4'd9 || outs !== EXP_BEQ) begin
            errors++; $display("FAIL beq_exec: got state %0d outs %h want 9 %h",
                               state_o, outs, EXP_BEQ);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd1) begin
            errors++; $display("FAIL beq_next: got %0d want 1", state_o);
        end
    endtask

    task automatic test_illegal();
        opcode    = 6'h3F;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (state_o !== 4'd2 || outs !== EXP_DECODE_ILL) begin
            errors++; $display("FAIL illegal_decode: got state %0d outs %h want 2 %h",
                               state_o, outs, EXP_DECODE_ILL);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd1 || outs !== EXP_FETCH_RDY) begin
            errors++; $display("FAIL illegal_next: got state %0d outs %h want 1 %h",
                               state_o, outs, EXP_FETCH_RDY);
        end
    endtask

    task automatic test_fetch_stall();
        mem_ready = 1'b0;
        opcode    = 6'h02;
        #1;
        checks++;
        if (state_o !== 4'd1 || outs !== EXP_FETCH_WAIT) begin
            errors++; $display("FAIL fetch_wait0: got state %0d outs %h want 1 %h",
                               state_o, outs, EXP_FETCH_WAIT);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd1 || outs !== EXP_FETCH_WAIT) begin
            errors++; $display("FAIL fetch_wait1: got state %0d outs %h want 1 %h",
                               state_o, outs, EXP_FETCH_WAIT);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== EXP_FETCH_RDY) begin
            errors++; $display("FAIL fetch_pulse: got %h want %h", outs, EXP_FETCH_RDY);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd2 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
            errors++; $display("FAIL fetch_single_pulse: got state %0d ir %b pc %b want 2 0 0",
                               state_o, ir_write, pc_write);
        end
        // Continue the jump that was fetched.
        @(negedge clk);
        checks++;
        if (state_o !== 4'd12 || outs !== EXP_JEX) begin
            errors++; $display("FAIL jump_exec: got state %0d outs %h want 12 %h",
                               state_o, outs, EXP_JEX);
        end
        @(negedge clk);
    endtask

    // SW then ADDI issued back to back.
    task automatic test_back_to_back();
        mem_ready = 1'b1;
        opcode    = 6'h2B;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state_o !== 4'd6 || outs !== EXP_MEMWR) begin
            errors++; $display("FAIL sw_memwr: got state %0d outs %h want 6 %h",
                               state_o, outs, EXP_MEMWR);
        end
        @(negedge clk);
        opcode = 6'h08;
        checks++;
        if (state_o !== 4'd1) begin
            errors++; $display("FAIL sw_next: got %0d want 1", state_o);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state_o !== 4'd10 || outs !== EXP_AIEX) begin
            errors++; $display("FAIL addi_ex: got state %0d outs %h want 10 %h",
                               state_o, outs, EXP_AIEX);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd11 || outs !== EXP_AIWB) begin
            errors++; $display("FAIL addi_wb: got state %0d outs %h want 11 %h",
                               state_o, outs, EXP_AIWB);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset while stalled in MEMRD.
    task automatic test_reset_mid_memrd();
        opcode    = 6'h23;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        checks++;
        if (state_o !== 4'd4) begin
            errors++; $display("FAIL mid_reach_memrd: got %0d want 4", state_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || outs !== EXP_ZERO) begin
            errors++; $display("FAIL mid_async_reset: got state %0d outs %h want 0 %h",
                               state_o, outs, EXP_ZERO);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (state_o !== 4'd1) begin
            errors++; $display("FAIL mid_release: got %0d want 1", state_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_fetch_stall();
        test_back_to_back();
        test_reset_mid_memrd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
